// File: rtl/sv39_pte_mapper_pkg.sv
// Shared Sv39 definitions: PTE layout, level encodings, satp mode and mapper error codes.
// Usable by both the page-table mapper and the address translator.
package sv39_pte_mapper_pkg;

  localparam logic [3:0] SatpModeSv39 = 4'd8;

  localparam logic [1:0] Lvl2M  = 2'd1;
  localparam logic [1:0] Lvl1G  = 2'd2;
  localparam logic [1:0] LvlBad = 2'd3;

  localparam int unsigned PteV = 0;
  localparam int unsigned PteR = 1;
  localparam int unsigned PteX = 3;

  localparam logic [2:0] ErrOk        = 3'd0;
  localparam logic [2:0] ErrBare      = 3'd1;
  localparam logic [2:0] ErrLevel     = 3'd2;
  localparam logic [2:0] ErrMisalign  = 3'd3;
  localparam logic [2:0] ErrExists    = 3'd4;
  localparam logic [2:0] ErrSuperpage = 3'd5;
  localparam logic [2:0] ErrOom       = 3'd6;

  typedef struct packed {
    logic [9:0]  reserved;
    logic [43:0] ppn;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } pte_t;

  typedef enum logic [2:0] {StIdle, StCheck, StRd, StZero, StLink, StLeaf, StFin} state_e;

  // vpn holds va[38:12]; returns the 9-bit index used at the given level
  function automatic logic [8:0] vpn_sel(input logic [26:0] vpn, input logic [1:0] lvl);
    case (lvl)
      Lvl1G:   vpn_sel = vpn[26:18];
      Lvl2M:   vpn_sel = vpn[17:9];
      default: vpn_sel = vpn[8:0];
    endcase
  endfunction

endpackage

// File: rtl/sv39_pte_mapper.sv
// Sv39 page-table writer: walks from the satp root, allocates and zero-fills missing
// tables from a free-page pool, links them and writes the requested leaf PTE.
module sv39_pte_mapper
  import sv39_pte_mapper_pkg::*;
#(
  parameter bit ZERO_FILL = 1'b1,
  parameter bit SET_AD    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] satp,
  input  logic        pool_load,
  input  logic [43:0] pool_base,
  input  logic [43:0] pool_limit,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_vaddr,
  input  logic [63:0] req_paddr,
  input  logic [1:0]  req_level,
  input  logic [7:0]  req_flags,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ack,
  output logic        done,
  output logic        err,
  output logic [2:0]  err_code,
  output logic [43:0] next_free
);

  state_e      state_q, state_d;
  logic [3:0]  mode_q, mode_d;
  logic [26:0] vpn_q, vpn_d;
  logic [43:0] ppn_q, ppn_d;
  logic [1:0]  level_q, level_d;
  logic [7:0]  flags_q, flags_d;
  logic [1:0]  lvl_q, lvl_d;
  logic [43:0] tbl_q, tbl_d;
  logic [43:0] new_q, new_d;
  logic [43:0] next_free_q, next_free_d;
  logic [43:0] limit_q, limit_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [2:0]  code_q, code_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [2:0]  err_code_q, err_code_d;

  logic [63:0] pte_addr;
  logic        rd_v, rd_leaf;
  pte_t        leaf_pte, link_pte;

  assign pte_addr = {8'b0, tbl_q, vpn_sel(vpn_q, lvl_q), 3'b000};
  assign rd_v     = mem_rdata[PteV];
  assign rd_leaf  = mem_rdata[PteR] | mem_rdata[PteX];

  always_comb begin
    leaf_pte     = '0;
    leaf_pte.ppn = ppn_q;
    if (level_q == Lvl2M) leaf_pte.ppn[8:0] = '0;
    if (level_q == Lvl1G) leaf_pte.ppn[17:0] = '0;
    {leaf_pte.d, leaf_pte.a} = SET_AD ? 2'b11 : flags_q[7:6];
    {leaf_pte.g, leaf_pte.u, leaf_pte.x, leaf_pte.w, leaf_pte.r} = flags_q[5:1];
    leaf_pte.v   = 1'b1;
    link_pte     = '0;
    link_pte.ppn = new_q;
    link_pte.v   = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    vpn_d       = vpn_q;
    ppn_d       = ppn_q;
    level_d     = level_q;
    flags_d     = flags_q;
    lvl_d       = lvl_q;
    tbl_d       = tbl_q;
    new_d       = new_q;
    next_free_d = next_free_q;
    limit_d     = limit_q;
    cnt_d       = cnt_q;
    code_d      = code_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    err_d       = err_q;
    err_code_d  = err_code_q;

    unique case (state_q)
      StIdle: begin
        // Pool load takes effect before a same-cycle request is walked
        if (pool_load) begin
          next_free_d = pool_base;
          limit_d     = pool_limit;
        end
        if (req_valid) begin
          mode_d     = satp[63:60];
          tbl_d      = satp[43:0];
          vpn_d      = req_vaddr[38:12];
          ppn_d      = req_paddr[55:12];
          level_d    = req_level;
          flags_d    = req_flags;
          lvl_d      = Lvl1G;
          code_d     = ErrOk;
          err_d      = 1'b0;
          err_code_d = ErrOk;
          state_d    = StCheck;
        end
      end
      StCheck: begin
        state_d = StFin;
        if (mode_q != SatpModeSv39) begin
          code_d = ErrBare;
        end else if (level_q == LvlBad) begin
          code_d = ErrLevel;
        end else if ((level_q == Lvl2M && ppn_q[8:0] != '0) ||
                     (level_q == Lvl1G && ppn_q[17:0] != '0)) begin
          code_d = ErrMisalign;
        end else begin
          state_d = StRd;
        end
      end
      StRd: begin
        if (!mem_req_q) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = pte_addr;
          mem_wdata_d = '0;
        end else if (mem_ack) begin
          mem_req_d = 1'b0;
          if (lvl_q == level_q) begin
            if (rd_v) begin
              code_d  = ErrExists;
              state_d = StFin;
            end else begin
              state_d = StLeaf;
            end
          end else if (rd_v && rd_leaf) begin
            code_d  = ErrSuperpage;
            state_d = StFin;
          end else if (rd_v) begin
            tbl_d = mem_rdata[53:10];
            lvl_d = lvl_q - 2'd1;
          end else if (next_free_q == limit_q) begin
            code_d  = ErrOom;
            state_d = StFin;
          end else begin
            new_d   = next_free_q;
            cnt_d   = '0;
            state_d = ZERO_FILL ? StZero : StLink;
          end
        end
      end
      StZero: begin
        if (!mem_req_q) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {8'b0, new_q, cnt_q, 3'b000};
          mem_wdata_d = '0;
        end else if (mem_ack) begin
          mem_req_d = 1'b0;
          cnt_d     = cnt_q + 9'd1;
          if (cnt_q == 9'd511) state_d = StLink;
        end
      end
      StLink: begin
        if (!mem_req_q) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = pte_addr;
          mem_wdata_d = link_pte;
        end else if (mem_ack) begin
          // The page is consumed only once it is linked, so an aborted walk leaks nothing
          mem_req_d   = 1'b0;
          next_free_d = next_free_q + 44'd1;
          tbl_d       = new_q;
          lvl_d       = lvl_q - 2'd1;
          state_d     = StRd;
        end
      end
      StLeaf: begin
        if (!mem_req_q) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = pte_addr;
          mem_wdata_d = leaf_pte;
        end else if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = StFin;
        end
      end
      StFin: begin
        done_d     = 1'b1;
        err_d      = (code_q != ErrOk);
        err_code_d = code_q;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      mode_q      <= '0;
      vpn_q       <= '0;
      ppn_q       <= '0;
      level_q     <= '0;
      flags_q     <= '0;
      lvl_q       <= '0;
      tbl_q       <= '0;
      new_q       <= '0;
      next_free_q <= '0;
      limit_q     <= '0;
      cnt_q       <= '0;
      code_q      <= ErrOk;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ErrOk;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      vpn_q       <= vpn_d;
      ppn_q       <= ppn_d;
      level_q     <= level_d;
      flags_q     <= flags_d;
      lvl_q       <= lvl_d;
      tbl_q       <= tbl_d;
      new_q       <= new_d;
      next_free_q <= next_free_d;
      limit_q     <= limit_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign next_free = next_free_q;

  logic unused_bits;
  assign unused_bits = ^{satp[59:44], req_vaddr[63:39], req_vaddr[11:0], req_paddr[63:56],
                         req_paddr[11:0], mem_rdata[63:54], mem_rdata[9:4], mem_rdata[2]};

endmodule
